// File: rtl/pkt_residue_dsc_req_gen.sv
// Metadata pass-through stage that tracks per-queue residue and queues extra descriptor requests.
// Optional statistics counters are built when DSC_REQ_STATS_EN is defined.
package pkt_residue_dsc_req_gen_pkg;
    localparam int PKT_QID_W = 16;
    typedef struct packed {
        logic [PKT_QID_W-1:0] pkt_queue_id;
        logic                 needs_dsc;
        logic [31:0]          pkt_addr;
        logic [15:0]          pkt_size;
    } pkt_meta_with_queues_t;
endpackage

module pkt_residue_dsc_req_gen
    import pkt_residue_dsc_req_gen_pkg::*;
#(
    parameter int NB_QUEUES      = 512,
    parameter int DSC_FIFO_DEPTH = NB_QUEUES,
    localparam int QID_W = $clog2(NB_QUEUES),
    localparam int CNT_W = $clog2(DSC_FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  pkt_meta_with_queues_t in_meta_data,
    input  logic                  in_meta_valid,
    output logic                  in_meta_ready,
    output pkt_meta_with_queues_t out_meta_data,
    output logic                  out_meta_valid,
    input  logic                  out_meta_ready,
    input  logic                  queue_updated,
    input  logic [QID_W-1:0]      updated_queue_idx,
    output logic [QID_W-1:0]      dsc_req_queue_id,
    output logic                  dsc_req_superseded,
    output logic                  dsc_req_valid,
    input  logic                  dsc_req_ready,
    output logic [CNT_W-1:0]      dsc_req_count,
    output logic [31:0]           stat_residue_reqs,
    output logic [31:0]           stat_superseded
);
    localparam int PTR_W = (DSC_FIFO_DEPTH > 1) ? $clog2(DSC_FIFO_DEPTH) : 1;

    logic                  out_valid_q, out_valid_d;
    pkt_meta_with_queues_t out_data_q, out_data_d;
    logic [NB_QUEUES-1:0]  res_q, res_d, pend_q, pend_d, sup_q, sup_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [QID_W-1:0]      mem_q [DSC_FIFO_DEPTH];

    logic             acc, nd, pop, push, full, same, eff, pend_now;
    logic [QID_W-1:0] bq, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DSC_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_meta_ready      = !out_valid_q || out_meta_ready;
    assign out_meta_valid     = out_valid_q;
    assign out_meta_data      = out_data_q;
    assign dsc_req_valid      = count_q != '0;
    assign dsc_req_count      = count_q;
    assign head               = mem_q[rd_ptr_q];
    assign dsc_req_queue_id   = head;
    assign dsc_req_superseded = sup_q[head];
    assign full               = count_q == CNT_W'(DSC_FIFO_DEPTH);

    always_comb begin
        acc      = in_meta_valid && in_meta_ready;
        bq       = in_meta_data.pkt_queue_id[PKT_QID_W-1 -: QID_W];
        nd       = in_meta_data.needs_dsc;
        pop      = dsc_req_valid && dsc_req_ready;
        res_d    = res_q;
        pend_d   = pend_q;
        sup_d    = sup_q;
        push     = 1'b0;
        if (acc) begin
            res_d[bq] = !nd;
            if (nd && pend_q[bq]) sup_d[bq] = 1'b1;
        end
        if (pop) begin
            pend_d[head] = 1'b0;
            sup_d[head]  = 1'b0;
        end
        // A request popped this cycle no longer covers new residue
        same     = acc && (bq == updated_queue_idx);
        eff      = res_q[updated_queue_idx] || (same && !nd);
        pend_now = pend_q[updated_queue_idx] && !(pop && head == updated_queue_idx);
        if (queue_updated && !(same && nd) && eff) begin
            res_d[updated_queue_idx] = 1'b0;
            if (!pend_now) begin
                push                      = 1'b1;
                pend_d[updated_queue_idx] = 1'b1;
                sup_d[updated_queue_idx]  = 1'b0;
            end
        end
        out_valid_d = acc || (out_valid_q && !out_meta_ready);
        out_data_d  = acc ? in_meta_data : out_data_q;
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            res_q       <= '0;
            pend_q      <= '0;
            sup_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            res_q       <= res_d;
            pend_q      <= pend_d;
            sup_q       <= sup_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && (!full || pop)) mem_q[wr_ptr_q] <= updated_queue_idx;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

`ifdef DSC_REQ_STATS_EN
    logic [31:0] stat_res_q, stat_res_d, stat_sup_q, stat_sup_d;

    always_comb begin
        stat_res_d = stat_res_q + 32'(push);
        stat_sup_d = stat_sup_q + 32'(pop && sup_q[head]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_res_q <= '0;
            stat_sup_q <= '0;
        end else begin
            stat_res_q <= stat_res_d;
            stat_sup_q <= stat_sup_d;
        end
    end

    assign stat_residue_reqs = stat_res_q;
    assign stat_superseded   = stat_sup_q;
`else
    assign stat_residue_reqs = '0;
    assign stat_superseded   = '0;
`endif
endmodule

// File: tb/tb_pkt_residue_dsc_req_gen.sv
// Randomized scoreboard bench for pkt_residue_dsc_req_gen.
// A set-based reference model predicts meta beats, requests and counters.
module tb_pkt_residue_dsc_req_gen;
    import pkt_residue_dsc_req_gen_pkg::*;

    localparam int NQ = 512;
    localparam int QW = 9;
    localparam int LOW_W = PKT_QID_W - QW;

    logic clk = 0;
    logic rst_n = 0;
    pkt_meta_with_queues_t in_meta_data = '0, out_meta_data;
    logic in_meta_valid = 0, in_meta_ready, out_meta_valid, out_meta_ready = 1;
    logic queue_updated = 0;
    logic [QW-1:0] updated_queue_idx = '0, dsc_req_queue_id;
    logic dsc_req_superseded, dsc_req_valid, dsc_req_ready = 1;
    logic [QW:0] dsc_req_count;
    logic [31:0] stat_residue_reqs, stat_superseded;

    int tests = 0;
    int fails = 0;

    pkt_residue_dsc_req_gen dut (
        .clk(clk), .rst_n(rst_n),
        .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid),
        .in_meta_ready(in_meta_ready),
        .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid),
        .out_meta_ready(out_meta_ready),
        .queue_updated(queue_updated), .updated_queue_idx(updated_queue_idx),
        .dsc_req_queue_id(dsc_req_queue_id),
        .dsc_req_superseded(dsc_req_superseded),
        .dsc_req_valid(dsc_req_valid), .dsc_req_ready(dsc_req_ready),
        .dsc_req_count(dsc_req_count),
        .stat_residue_reqs(stat_residue_reqs),
        .stat_superseded(stat_superseded)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int qid; bit sup; } req_t;
    bit m_res[NQ], m_pend[NQ], m_sup[NQ];
    int m_fifo[$];
    req_t exp_req[$];
    pkt_meta_with_queues_t exp_meta[$];
    bit m_out_valid;
    int unsigned m_stat_res, m_stat_sup;
    bit s_in_ready, s_out_valid, s_req_valid;
    int s_count;
    int unsigned s_stat_res, s_stat_sup;

    function automatic int qid_of(pkt_meta_with_queues_t d);
        return int'(d.pkt_queue_id[PKT_QID_W-1 -: QW]);
    endfunction

    always @(negedge clk) begin : model
        bit acc, nd;
        int bq, uq, h;
        if (!rst_n) begin
            foreach (m_res[i]) begin m_res[i] = 0; m_pend[i] = 0; m_sup[i] = 0; end
            m_fifo.delete(); exp_req.delete(); exp_meta.delete();
            m_out_valid = 0; m_stat_res = 0; m_stat_sup = 0;
        end
        s_in_ready  = !m_out_valid || out_meta_ready;
        s_out_valid = m_out_valid;
        s_req_valid = m_fifo.size() != 0;
        s_count     = m_fifo.size();
        s_stat_res  = m_stat_res;
        s_stat_sup  = m_stat_sup;
        if (rst_n) begin
            acc = in_meta_valid && s_in_ready;
            bq  = qid_of(in_meta_data);
            nd  = in_meta_data.needs_dsc;
            uq  = int'(updated_queue_idx);
            if (acc) exp_meta.push_back(in_meta_data);
            m_out_valid = acc || (m_out_valid && !out_meta_ready);
            if (s_req_valid && dsc_req_ready) begin
                h = m_fifo.pop_front();
                exp_req.push_back('{h, m_sup[h]});
                if (m_sup[h]) m_stat_sup++;
                m_pend[h] = 0;
                m_sup[h] = 0;
            end
            if (acc) begin
                m_res[bq] = !nd;
                if (nd && m_pend[bq]) m_sup[bq] = 1;
            end
            if (queue_updated && !(acc && bq == uq && nd) && m_res[uq]) begin
                m_res[uq] = 0;
                if (!m_pend[uq]) begin
                    m_fifo.push_back(uq);
                    m_pend[uq] = 1;
                    m_sup[uq] = 0;
                    m_stat_res++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        req_t r;
        #1;
        chk("in_ready", in_meta_ready, s_in_ready);
        chk("out_valid", out_meta_valid, s_out_valid);
        chk("req_valid", dsc_req_valid, s_req_valid);
        chk("req_count", dsc_req_count, s_count);
`ifdef DSC_REQ_STATS_EN
        chk("stat_res", stat_residue_reqs, s_stat_res);
        chk("stat_sup", stat_superseded, s_stat_sup);
`else
        chk("stat_res_off", stat_residue_reqs, 0);
        chk("stat_sup_off", stat_superseded, 0);
`endif
        if (out_meta_valid) begin
            if (exp_meta.size() == 0) chk("meta_unexpected", 1, 0);
            else begin
                chk("meta_data", out_meta_data, exp_meta[0]);
                if (out_meta_ready) void'(exp_meta.pop_front());
            end
        end
        if (dsc_req_valid && dsc_req_ready) begin
            if (exp_req.size() == 0) chk("req_unexpected", 1, 0);
            else begin
                r = exp_req.pop_front();
                chk("req_qid", dsc_req_queue_id, r.qid);
                chk("req_sup", dsc_req_superseded, r.sup);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic pkt_meta_with_queues_t mk(int q, bit nd);
        pkt_meta_with_queues_t m;
        m.pkt_queue_id = (PKT_QID_W'(q) << LOW_W) | PKT_QID_W'($urandom_range(0, (1 << LOW_W) - 1));
        m.needs_dsc    = nd;
        m.pkt_addr     = $urandom;
        m.pkt_size     = 16'($urandom);
        return m;
    endfunction

    task automatic send(int q, bit nd);
        int n = 0;
        in_meta_valid = 1;
        in_meta_data  = mk(q, nd);
        #1;
        while (!in_meta_ready && n < 100) begin cyc(); #1; n++; end
        if (n == 100) chk("send_timeout", 1, 0);
        cyc();
        in_meta_valid = 0;
    endtask

    task automatic upd(int q);
        queue_updated     = 1;
        updated_queue_idx = QW'(q);
        cyc();
        queue_updated = 0;
    endtask

    task automatic beat_upd(int q, bit nd);
        in_meta_valid     = 1;
        in_meta_data      = mk(q, nd);
        queue_updated     = 1;
        updated_queue_idx = QW'(q);
        cyc();
        in_meta_valid = 0;
        queue_updated = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) cyc();
        rst_n = 1;
        cyc();
    endtask

    initial begin
        int sent, n;
        bit acc;
        repeat (3) cyc();
        chk("rst_out_valid", out_meta_valid, 0);
        chk("rst_req_valid", dsc_req_valid, 0);
        rst_n = 1;
        cyc();

        // residue after a covered packet -> one request, valid the cycle after update
        send(3, 1); send(3, 0); send(3, 0);
        upd(3);
        chk("t1_valid", dsc_req_valid, 1);
        chk("t1_qid", dsc_req_queue_id, 3);
        chk("t1_sup", dsc_req_superseded, 0);
        repeat (2) cyc();

        // covered-only queue -> no request
        send(5, 1); upd(5);
        repeat (2) cyc();
        chk("t2_count", dsc_req_count, 0);

        // dedup and supersede
        dsc_req_ready = 0;
        send(7, 0); upd(7); upd(7);
        chk("t3_count", dsc_req_count, 1);
        send(7, 1);
        chk("t3_sup", dsc_req_superseded, 1);
        dsc_req_ready = 1;
        cyc();
        chk("t3_drained", dsc_req_count, 0);

        // same-cycle beat and update
        beat_upd(2, 0);
        chk("t4_push", dsc_req_valid, 1);
        cyc();
        beat_upd(2, 1);
        chk("t4_nopush", dsc_req_valid, 0);
        cyc();

        // output stall during a 10-beat burst
        sent = 0;
        for (int i = 0; i < 40 && sent < 10; i++) begin
            in_meta_valid  = 1;
            in_meta_data   = mk(sent % 4 + 10, 1);
            out_meta_ready = !(i >= 3 && i < 8);
            #1;
            acc = in_meta_ready;
            if (i >= 4 && i < 8) chk("stall_in_ready", in_meta_ready, 0);
            cyc();
            if (acc) sent++;
        end
        chk("burst_sent", sent, 10);
        in_meta_valid = 0;
        out_meta_ready = 1;
        repeat (3) cyc();

        // every queue with residue, all updates queued, then drain
        do_reset();
        dsc_req_ready = 0;
        for (int q = 0; q < NQ; q++) send(q, 0);
        for (int i = 0; i < NQ; i++) upd((i * 37 + 11) % NQ);
        chk("all_count", dsc_req_count, NQ);
        dsc_req_ready = 1;
        n = 0;
        while (dsc_req_count != 0 && n < 2 * NQ) begin cyc(); n++; end
        chk("all_drained", dsc_req_count, 0);
`ifdef DSC_REQ_STATS_EN
        chk("all_stat", stat_residue_reqs, NQ);
`endif

        // randomized traffic with a reset in the middle
        for (int i = 0; i < 3000; i++) begin
            in_meta_valid     = $urandom_range(0, 99) < 60;
            in_meta_data      = mk($urandom_range(0, 7), $urandom_range(0, 2) == 0);
            queue_updated     = $urandom_range(0, 99) < 30;
            updated_queue_idx = QW'($urandom_range(0, 7));
            out_meta_ready    = $urandom_range(0, 99) < 75;
            dsc_req_ready     = $urandom_range(0, 99) < 40;
            if (i == 1500) rst_n = 0;
            if (i == 1503) rst_n = 1;
            cyc();
        end
        in_meta_valid = 0;
        queue_updated = 0;
        out_meta_ready = 1;
        dsc_req_ready = 1;
        repeat (20) cyc();
        chk("end_req_q", exp_req.size(), 0);
        chk("end_meta_q", exp_meta.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
